// File: rtl/t03_nes_pkg.sv
// Shared types and constants for the NES gamepad poller.
// Holds the poll FSM state enum, the per-byte button bit positions and
// the width of the presented data word.
package t03_nes_pkg;

    localparam int NES_WORD_W = 32;

    // Bit position of each button inside a pad byte (first bit shifted out = A)
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        BIT_LO,
        BIT_HI,
        DONE
    } nes_state_t;

    // Largest of three cycle counts; sizes the shared phase counter
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/t03_sync2.sv
// Two-flop synchronizer for an asynchronous pad data line.
// Resets to 1, the idle (nothing pressed / unplugged) level of the line.
module t03_sync2 (
    input  logic clk,
    input  logic nRST,
    input  logic d,
    output logic q
);

    logic meta_reg;

    // Two-stage resynchronization into the clk domain
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            meta_reg <= 1'b1;
            q        <= 1'b1;
        end else begin
            meta_reg <= d;
            q        <= meta_reg;
        end
    end

endmodule

// File: rtl/t03_nes_poller.sv
// Free-running poller for two NES gamepads (latch / clock / serial).
// Each frame: POLL_CYCLES idle, LATCH_CYCLES latch pulse, then 8 bit
// samples separated by 7 shift-clock high phases, then a single DONE
// cycle that publishes both bytes and pulses nes_confirm.
// Optional build macro T03_NES_PRESS_EDGE_EN adds newly-pressed flags
// in nes_data[31:16]; otherwise those bits are tied to zero.
module t03_nes_poller
    import t03_nes_pkg::*;
#(
    parameter int POLL_CYCLES  = 166_667,
    parameter int LATCH_CYCLES = 120,
    parameter int HALF_CYCLES  = 60
) (
    input  logic                  clk,
    input  logic                  nRST,
    input  logic                  p1_serial,
    input  logic                  p2_serial,
    output logic                  nes_latch,
    output logic                  nes_pulse,
    output logic [NES_WORD_W-1:0] nes_data,
    output logic                  nes_confirm
);

    localparam int CNT_W = $clog2(max3(POLL_CYCLES, LATCH_CYCLES, HALF_CYCLES));

    nes_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bi_reg, bi_next;
    logic             shift_en;
    logic             load_en;

    logic [1:0]       pad_serial;
    logic [1:0][7:0]  pad_sh;
    logic [15:0]      data_lo_reg;
    logic [15:0]      data_hi;

    assign pad_serial = {p2_serial, p1_serial};

    // Per-pad synchronizer and private shift register (pad 1 = index 0)
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_pad
            logic       sync_q;
            logic [7:0] sh_reg;

            t03_sync2 u_sync (
                .clk  (clk),
                .nRST (nRST),
                .d    (pad_serial[gi]),
                .q    (sync_q)
            );

            // Capture the inverted (pressed = 1) bit on the last BIT_LO cycle
            always_ff @(posedge clk or negedge nRST) begin
                if (!nRST) begin
                    sh_reg <= '0;
                end else if (shift_en) begin
                    sh_reg[bi_reg] <= ~sync_q;
                end
            end

            assign pad_sh[gi] = sh_reg;
        end
    endgenerate

    // FSM state, shared phase counter and bit index registers
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            bi_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bi_reg    <= bi_next;
        end
    end

    // Next-state logic: every state counts cycles and leaves on its last one
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + CNT_W'(1);
        bi_next    = bi_reg;
        shift_en   = 1'b0;
        load_en    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cnt_reg == CNT_W'(POLL_CYCLES - 1)) begin
                    state_next = LATCH;
                    cnt_next   = '0;
                end
            end
            LATCH: begin
                if (cnt_reg == CNT_W'(LATCH_CYCLES - 1)) begin
                    state_next = BIT_LO;
                    cnt_next   = '0;
                    bi_next    = 3'(BTN_A);
                end
            end
            BIT_LO: begin
                if (cnt_reg == CNT_W'(HALF_CYCLES - 1)) begin
                    shift_en = 1'b1;
                    cnt_next = '0;
                    // The last bit needs no trailing shift clock
                    state_next = (bi_reg == 3'(BTN_RIGHT)) ? DONE : BIT_HI;
                end
            end
            BIT_HI: begin
                if (cnt_reg == CNT_W'(HALF_CYCLES - 1)) begin
                    state_next = BIT_LO;
                    cnt_next   = '0;
                    bi_next    = bi_reg + 3'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
                cnt_next   = '0;
                load_en    = 1'b1;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Pad-side strobes decode straight from state so reset clears them at once
    assign nes_latch = (state_reg == LATCH);
    assign nes_pulse = (state_reg == BIT_HI);

    // Publish the completed button bytes and the one-cycle confirm strobe
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            data_lo_reg <= '0;
            nes_confirm <= 1'b0;
        end else begin
            nes_confirm <= load_en;
            if (load_en) begin
                data_lo_reg <= pad_sh;
            end
        end
    end

`ifdef T03_NES_PRESS_EDGE_EN
    logic [15:0] edge_reg;

    // Newly pressed = pressed now and not pressed in the previously published byte
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            edge_reg <= '0;
        end else if (load_en) begin
            edge_reg <= pad_sh & ~data_lo_reg;
        end
    end

    assign data_hi = edge_reg;
`else
    assign data_hi = '0;
`endif

    assign nes_data = {data_hi, data_lo_reg};

endmodule

// File: tb/tb_t03_nes_poller.sv
// Self-checking bench for t03_nes_poller with POLL=10, LATCH=4, HALF=3.
// Two behavioural 4021-style pads drive the serial lines; a frame-level
// reference (buttons held when latch falls, plus new-press flags when
// T03_NES_PRESS_EDGE_EN is defined) predicts every published word.
module tb_t03_nes_poller;
    import t03_nes_pkg::*;

    localparam int POLL  = 10;
    localparam int LATCH = 4;
    localparam int HALF  = 3;
    localparam int FRAME = POLL + LATCH + 8 * HALF + 7 * HALF + 1;
    localparam logic [7:0] ALL_BTN = 8'((1 << BTN_A) | (1 << BTN_B) | (1 << BTN_SELECT) |
                                        (1 << BTN_START) | (1 << BTN_UP) | (1 << BTN_DOWN) |
                                        (1 << BTN_LEFT) | (1 << BTN_RIGHT));
`ifdef T03_NES_PRESS_EDGE_EN
    localparam bit EDGE_BUILD = 1'b1;
`else
    localparam bit EDGE_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nRST = 1'b0;
    logic        p1_serial, p2_serial;
    logic        nes_latch, nes_pulse, nes_confirm;
    logic [31:0] nes_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    t03_nes_poller #(
        .POLL_CYCLES  (POLL),
        .LATCH_CYCLES (LATCH),
        .HALF_CYCLES  (HALF)
    ) dut (
        .clk         (clk),
        .nRST        (nRST),
        .p1_serial   (p1_serial),
        .p2_serial   (p2_serial),
        .nes_latch   (nes_latch),
        .nes_pulse   (nes_pulse),
        .nes_data    (nes_data),
        .nes_confirm (nes_confirm)
    );

    // Pad model: parallel inputs visible while latched, frozen at latch fall,
    // one position further per shift-clock rising edge; line low = pressed.
    logic [7:0] p1_btn = 8'h00, p2_btn = 8'h00;
    logic [7:0] p1_load = 8'h00, p2_load = 8'h00;
    logic [2:0] pad_sel = 3'd0;

    always @(posedge nes_latch) pad_sel = 3'd0;
    always @(posedge nes_pulse) if (pad_sel != 3'd7) pad_sel = pad_sel + 3'd1;
    always @(negedge nes_latch) begin
        p1_load = p1_btn;
        p2_load = p2_btn;
    end

    assign p1_serial = nes_latch ? ~p1_btn[0] : ~p1_load[pad_sel];
    assign p2_serial = nes_latch ? ~p2_btn[0] : ~p2_load[pad_sel];

    // Reference-model memory: last published word (cleared by reset)
    logic [31:0] held_exp = 32'h0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Run one frame from a known IDLE cycle offset up to its confirm strobe,
    // checking timing, the published word, the strobe width and data hold.
    task automatic run_frame(input string tag, input int cyc0,
                             input logic [7:0] a1, input logic [7:0] a2,
                             input bit chg, input logic [7:0] c1, input logic [7:0] c2);
        int cyc = cyc0;
        int lat_first = -1;
        int lat_cnt = 0;
        int runs = 0;
        int hi_run = 0;
        int lo_run = 0;
        int hi_bad = 0;
        int lo_bad = 0;
        int held_bad = 0;
        bit prev_p = 1'b0;
        bit done = 1'b0;
        logic [7:0]  f1, f2;
        logic [31:0] exp;
        p1_btn = a1;
        p2_btn = a2;
        while (!done && cyc < cyc0 + 200) begin
            @(negedge clk);
            cyc++;
            if (nes_latch) begin
                lat_cnt++;
                if (lat_first < 0) begin
                    lat_first = cyc;
                    if (chg) begin
                        p1_btn = c1;
                        p2_btn = c2;
                    end
                end
            end
            if (nes_pulse) begin
                if (!prev_p && runs > 0 && lo_run != HALF) lo_bad++;
                hi_run++;
                lo_run = 0;
            end else begin
                if (prev_p) begin
                    runs++;
                    if (hi_run != HALF) hi_bad++;
                    hi_run = 0;
                end
                lo_run++;
            end
            prev_p = nes_pulse;
            if (nes_confirm) done = 1'b1;
            else if (nes_data !== held_exp) held_bad++;
        end
        if (!done) check_eq({tag, " confirm timeout"}, 32'd0, 32'd1);
        f1 = chg ? c1 : a1;
        f2 = chg ? c2 : a2;
        exp[15:0]  = {f2, f1};
        exp[31:16] = EDGE_BUILD ? ({f2, f1} & ~held_exp[15:0]) : 16'h0;
        $display("frame %s: data=%08h expected=%08h cycles=%0d latch_at=%0d pulses=%0d",
                 tag, nes_data, exp, cyc, lat_first, runs);
        check_eq({tag, " frame_len"}, cyc, FRAME);
        check_eq({tag, " latch_start"}, lat_first, POLL);
        check_eq({tag, " latch_width"}, lat_cnt, LATCH);
        check_eq({tag, " pulse_count"}, runs, 7);
        check_eq({tag, " pulse_hi_bad"}, hi_bad, 0);
        check_eq({tag, " pulse_lo_bad"}, lo_bad, 0);
        check_eq({tag, " data_held_bad"}, held_bad, 0);
        check_eq({tag, " data"}, nes_data, exp);
        held_exp = exp;
        @(negedge clk);
        check_eq({tag, " confirm_width"}, nes_confirm, 1'b0);
        check_eq({tag, " data_after"}, nes_data, exp);
    endtask

    initial begin
        int n;
        bit found;
        logic [7:0] r1, r2, s1, s2;
        bit rc;

        // Reset state
        nRST = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst latch", nes_latch, 1'b0);
        check_eq("rst pulse", nes_pulse, 1'b0);
        check_eq("rst data", nes_data, 32'h0);
        check_eq("rst confirm", nes_confirm, 1'b0);
        nRST = 1'b1;

        // Unplugged/idle pads, then A+Right on pad1 and Start on pad2
        run_frame("idle_pads", 0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
        run_frame("a_right_start", 1, 8'((1 << BTN_A) | (1 << BTN_RIGHT)),
                  8'(1 << BTN_START), 1'b0, 8'h00, 8'h00);
        check_eq("a_right_start word", nes_data[15:0], 16'h0881);

        // Buttons change while latched: only the final latched value counts
        run_frame("chg_in_latch", 1, 8'h55, 8'h0F, 1'b1, 8'hA3, 8'h3C);

        // Random frames
        for (int k = 0; k < 6; k++) begin
            r1 = 8'($urandom) & ALL_BTN;
            r2 = 8'($urandom) & ALL_BTN;
            s1 = 8'($urandom);
            s2 = 8'($urandom);
            rc = 1'($urandom_range(0, 1));
            run_frame($sformatf("rand%0d", k), 1, r1, r2, rc, s1, s2);
        end

        // Reset while the shift clock is high
        run_frame("pre_reset", 1, 8'hFF, 8'h5A, 1'b0, 8'h00, 8'h00);
        found = 1'b0;
        n = 0;
        while (!found && n < 200) begin
            @(negedge clk);
            n++;
            if (nes_pulse) found = 1'b1;
        end
        check_eq("reset wait bit_hi", found, 1'b1);
        nRST = 1'b0;
        #1;
        check_eq("midrst latch", nes_latch, 1'b0);
        check_eq("midrst pulse", nes_pulse, 1'b0);
        check_eq("midrst data", nes_data, 32'h0);
        check_eq("midrst confirm", nes_confirm, 1'b0);
        held_exp = 32'h0;
        @(negedge clk);
        nRST = 1'b1;
        run_frame("after_reset", 0, 8'h10, 8'h20, 1'b0, 8'h00, 8'h00);

        // Press A, then hold A: new-press flags only on the first frame
        run_frame("edge_clear", 1, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
        run_frame("edge_press", 1, 8'(1 << BTN_A), 8'h00, 1'b0, 8'h00, 8'h00);
        check_eq("edge_press hi", nes_data[31:16], EDGE_BUILD ? 16'h0001 : 16'h0000);
        run_frame("edge_hold", 1, 8'(1 << BTN_A), 8'h00, 1'b0, 8'h00, 8'h00);
        check_eq("edge_hold hi", nes_data[31:16], 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
